// File: rtl/half_line_packer.sv
// half_line_packer: splits active video lines into two half-line packets,
// buffers them in a two-bank ping-pong RAM and streams header + pixels out.
// Optional feature macro: HLP_STATS_EN (adds drop_cnt / pkt_cnt outputs).

module half_line_packer #(
    parameter logic [10:0] FRAME_WIDTH = 11'd1280,
    parameter logic [10:0] HALF_WIDTH  = FRAME_WIDTH / 11'd2,
    parameter int          ADDR_W      = 10
) (
    input  logic        pclk,
    input  logic        rstbtn_n,
    input  logic        video_en,
    input  logic [11:0] index,
    input  logic [10:0] video_hcnt,
    input  logic [10:0] video_vcnt,
    input  logic [23:0] rgb,
    output logic [23:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sof,
    output logic        out_eof,
    output logic        ovf
`ifdef HLP_STATS_EN
    ,
    output logic [15:0] drop_cnt,
    output logic [15:0] pkt_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2
    } rd_state_e;

    // Bank bookkeeping and writer state
    logic [1:0]        full_q;
    logic              wr_bank_q;
    logic              wr_active_q;
    logic              ovf_q;
    logic [23:0]       hdr_q [2];

    // Storage
    logic [23:0]       mem [2][1 << ADDR_W];
    logic [23:0]       ram_q;

    // Reader state
    rd_state_e         state_q;
    logic              rd_bank_q;
    logic [10:0]       rd_cnt_q;
    logic              rd_pend_q;
    logic              pend_eof_q;
    logic              out_valid_q;
    logic [23:0]       out_data_q;
    logic              out_sof_q;
    logic              out_eof_q;
    logic              skid_valid_q;
    logic [23:0]       skid_data_q;
    logic              skid_eof_q;

    // Writer decode
    logic              half_start;
    logic              claim;
    logic              drop;
    logic [10:0]       wr_off;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_en;
    logic              commit;

    assign half_start = video_en &&
                        (video_hcnt == 11'd0 || video_hcnt == HALF_WIDTH);
    assign claim   = half_start && !full_q[wr_bank_q];
    assign drop    = half_start && full_q[wr_bank_q];
    assign wr_off  = (video_hcnt >= HALF_WIDTH) ? video_hcnt - HALF_WIDTH
                                                : video_hcnt;
    assign wr_addr = wr_off[ADDR_W-1:0];
    assign wr_en   = half_start ? claim : (video_en && wr_active_q);
    assign commit  = wr_en && (wr_off == HALF_WIDTH - 11'd1);

    // Reader decode
    logic              pop;
    logic              rel;
    logic              rd_start;
    logic [10:0]       issue_idx;
    logic [1:0]        occ;
    logic              rd_issue;
    logic              issue_eof;
    logic [ADDR_W-1:0] rd_addr;
    logic [1:0]        set_v;
    logic [1:0]        clr_v;

    assign pop       = out_valid_q && out_ready;
    assign rel       = pop && out_eof_q;
    assign rd_start  = (state_q == IDLE) && full_q[rd_bank_q];
    assign issue_idx = rd_start ? 11'd0 : rd_cnt_q;
    // Words held or in flight once this cycle's pop is accounted for;
    // out register plus skid register give room for two.
    assign occ       = {1'b0, out_valid_q} + {1'b0, skid_valid_q}
                     + {1'b0, rd_pend_q} - {1'b0, pop};
    assign rd_issue  = (rd_start || (state_q != IDLE && rd_cnt_q < HALF_WIDTH))
                       && (occ < 2'd2);
    assign issue_eof = (issue_idx == HALF_WIDTH - 11'd1);
    assign rd_addr   = issue_idx[ADDR_W-1:0];

    assign set_v = commit ? (wr_bank_q ? 2'b10 : 2'b01) : 2'b00;
    assign clr_v = rel ? (rd_bank_q ? 2'b10 : 2'b01) : 2'b00;

    // Writer: claim a bank at half start, latch header, commit on last pixel
    always_ff @(posedge pclk or posedge rstbtn_n) begin
        if (rstbtn_n) begin
            wr_bank_q   <= 1'b0;
            wr_active_q <= 1'b0;
            ovf_q       <= 1'b0;
            hdr_q[0]    <= '0;
            hdr_q[1]    <= '0;
        end else begin
            ovf_q <= drop;
            if (commit) begin
                wr_active_q <= 1'b0;
                wr_bank_q   <= ~wr_bank_q;
            end else if (half_start) begin
                wr_active_q <= claim;
            end else if (!video_en) begin
                wr_active_q <= 1'b0;
            end
            if (claim) begin
                hdr_q[wr_bank_q] <= {index, video_vcnt,
                                     video_hcnt != 11'd0};
            end
        end
    end

    // Bank full flags: independent set (commit) and clear (eof handshake)
    always_ff @(posedge pclk or posedge rstbtn_n) begin
        if (rstbtn_n) begin
            full_q <= 2'b00;
        end else begin
            full_q <= (full_q | set_v) & ~clr_v;
        end
    end

    // Ping-pong RAM with one-cycle synchronous read
    always_ff @(posedge pclk) begin
        if (wr_en) begin
            mem[wr_bank_q][wr_addr] <= rgb;
        end
        if (rd_issue) begin
            ram_q <= mem[rd_bank_q][rd_addr];
        end
    end

    // Reader FSM with prefetch: out register backed by a skid register
    always_ff @(posedge pclk or posedge rstbtn_n) begin
        if (rstbtn_n) begin
            state_q      <= IDLE;
            rd_bank_q    <= 1'b0;
            rd_cnt_q     <= '0;
            rd_pend_q    <= 1'b0;
            pend_eof_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_sof_q    <= 1'b0;
            out_eof_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_eof_q   <= 1'b0;
        end else begin
            rd_pend_q <= rd_issue;
            if (rd_issue) begin
                pend_eof_q <= issue_eof;
                rd_cnt_q   <= issue_idx + 11'd1;
            end

            unique case (state_q)
                IDLE: if (rd_start) state_q <= HDR;
                HDR:  if (pop) state_q <= BODY;
                BODY: begin
                    if (rel) begin
                        state_q   <= IDLE;
                        rd_bank_q <= ~rd_bank_q;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (!out_valid_q || pop) begin
                if (skid_valid_q) begin
                    out_valid_q  <= 1'b1;
                    out_data_q   <= skid_data_q;
                    out_sof_q    <= 1'b0;
                    out_eof_q    <= skid_eof_q;
                    skid_valid_q <= rd_pend_q;
                    skid_data_q  <= ram_q;
                    skid_eof_q   <= pend_eof_q;
                end else if (rd_pend_q) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= ram_q;
                    out_sof_q   <= 1'b0;
                    out_eof_q   <= pend_eof_q;
                end else if (rd_start) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= hdr_q[rd_bank_q];
                    out_sof_q   <= 1'b1;
                    out_eof_q   <= 1'b0;
                end else begin
                    out_valid_q <= 1'b0;
                    out_sof_q   <= 1'b0;
                    out_eof_q   <= 1'b0;
                end
            end else if (rd_pend_q) begin
                skid_valid_q <= 1'b1;
                skid_data_q  <= ram_q;
                skid_eof_q   <= pend_eof_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sof   = out_sof_q;
    assign out_eof   = out_eof_q;
    assign ovf       = ovf_q;

`ifdef HLP_STATS_EN
    logic [15:0] drop_cnt_q;
    logic [15:0] pkt_cnt_q;

    // Saturating drop counter and wrapping packet counter
    always_ff @(posedge pclk or posedge rstbtn_n) begin
        if (rstbtn_n) begin
            drop_cnt_q <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            if (ovf_q && drop_cnt_q != 16'hFFFF) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
            if (rel) begin
                pkt_cnt_q <= pkt_cnt_q + 16'd1;
            end
        end
    end

    assign drop_cnt = drop_cnt_q;
    assign pkt_cnt  = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_half_line_packer.sv
// tb_half_line_packer: directed vectors for half_line_packer
// with FRAME_WIDTH=16 / HALF_WIDTH=8.

module tb_half_line_packer;

    logic        pclk = 1'b0;
    logic        rstbtn_n = 1'b1;
    logic        video_en = 1'b0;
    logic [11:0] index = '0;
    logic [10:0] video_hcnt = '0;
    logic [10:0] video_vcnt = '0;
    logic [23:0] rgb = '0;
    logic        out_ready = 1'b0;
    logic [23:0] out_data;
    logic        out_valid;
    logic        out_sof;
    logic        out_eof;
    logic        ovf;
`ifdef HLP_STATS_EN
    logic [15:0] drop_cnt;
    logic [15:0] pkt_cnt;
`endif

    half_line_packer #(
        .FRAME_WIDTH(11'd16),
        .HALF_WIDTH (11'd8),
        .ADDR_W     (3)
    ) dut (
        .pclk      (pclk),
        .rstbtn_n  (rstbtn_n),
        .video_en  (video_en),
        .index     (index),
        .video_hcnt(video_hcnt),
        .video_vcnt(video_vcnt),
        .rgb       (rgb),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sof   (out_sof),
        .out_eof   (out_eof),
        .ovf       (ovf)
`ifdef HLP_STATS_EN
        ,
        .drop_cnt  (drop_cnt),
        .pkt_cnt   (pkt_cnt)
`endif
    );

    always #5 pclk = ~pclk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int ovf_cnt = 0;
    bit ready_mode = 1'b0;
    bit ready_lvl = 1'b1;

    typedef struct {
        logic [25:0] w;
        int          c;
    } cap_t;
    cap_t cap[$];

    typedef struct {
        logic [11:0] idx;
        logic [10:0] vcnt;
        logic [23:0] base;
        bit          tog;
        logic [23:0] hdr_a;
        logic [23:0] hdr_b;
    } vec_t;
    vec_t vecs[4];

    function automatic void check(input string nm, input logic [63:0] act,
                                  input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // cycle counter for throughput checks
    always @(posedge pclk) cyc++;

    // ready driver: held level or toggling every cycle
    always @(posedge pclk) begin
        #1;
        out_ready = ready_mode ? ~out_ready : ready_lvl;
    end

    // monitor: capture handshakes, count ovf, check stall stability
    logic        prev_stall = 1'b0;
    logic [26:0] prev_w = '0;
    always @(negedge pclk) begin
        if (rstbtn_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("hold", {out_valid, out_sof, out_eof, out_data}, prev_w);
            if (out_valid && out_ready)
                cap.push_back('{w: {out_sof, out_eof, out_data}, c: cyc});
            if (ovf) ovf_cnt++;
            prev_stall = out_valid && !out_ready;
            prev_w = {out_valid, out_sof, out_eof, out_data};
        end
    end

    task automatic pix(input int c0, input int n, input logic [11:0] idx,
                       input logic [10:0] vc, input logic [23:0] base);
        for (int i = 0; i < n; i++) begin
            @(posedge pclk);
            #1;
            video_en   = 1'b1;
            video_hcnt = 11'(c0 + i);
            index      = idx;
            video_vcnt = vc;
            rgb        = base + 24'(c0 + i);
        end
        @(posedge pclk);
        #1;
        video_en   = 1'b0;
        video_hcnt = '0;
        repeat (4) @(posedge pclk);
    endtask

    task automatic wait_words(input int n, input string nm);
        for (int k = 0; k < 600 && cap.size() < n; k++) @(negedge pclk);
        repeat (30) @(negedge pclk);
        check({nm, "_cnt"}, cap.size(), n);
    endtask

    task automatic check_pkt(input int at, input logic [23:0] hdr,
                             input logic [23:0] pix0, input string nm);
        if (cap.size() < at + 9) begin
            check({nm, "_len"}, cap.size(), at + 9);
            return;
        end
        check({nm, "_hdr"}, cap[at].w, {2'b10, hdr});
        for (int i = 0; i < 8; i++)
            check({nm, "_px"}, cap[at + 1 + i].w,
                  {1'b0, i == 7, pix0 + 24'(i)});
    endtask

    task automatic do_reset();
        @(negedge pclk);
        rstbtn_n = 1'b1;
        repeat (3) @(negedge pclk);
        rstbtn_n = 1'b0;
        repeat (2) @(negedge pclk);
    endtask

    int o0;
    int nb;

    initial begin
        vecs[0] = '{12'd5,   11'd3,   24'h000000, 1'b0, 24'h005006, 24'h005007};
        vecs[1] = '{12'd5,   11'd3,   24'h000000, 1'b1, 24'h005006, 24'h005007};
        vecs[2] = '{12'hABC, 11'h7FF, 24'h100000, 1'b0, 24'hABCFFE, 24'hABCFFF};
        vecs[3] = '{12'hFFF, 11'd0,   24'hFFFFF0, 1'b1, 24'hFFF000, 24'hFFF001};

        // reset values
        repeat (3) @(negedge pclk);
        check("rst_valid", out_valid, 0);
        check("rst_sof", out_sof, 0);
        check("rst_eof", out_eof, 0);
        check("rst_ovf", ovf, 0);
        check("rst_data", out_data, 0);
        rstbtn_n = 1'b0;
        repeat (2) @(negedge pclk);

        // table-driven full lines
        for (int v = 0; v < 4; v++) begin
            ready_mode = vecs[v].tog;
            ready_lvl  = 1'b1;
            cap.delete();
            o0 = ovf_cnt;
            pix(0, 16, vecs[v].idx, vecs[v].vcnt, vecs[v].base);
            wait_words(18, "vec");
            check_pkt(0, vecs[v].hdr_a, vecs[v].base, "vecA");
            check_pkt(9, vecs[v].hdr_b, vecs[v].base + 24'd8, "vecB");
            check("vec_ovf", ovf_cnt - o0, 0);
            if (!vecs[v].tog && cap.size() >= 9)
                check("vec_rate", cap[8].c - cap[0].c, 8);
            ready_mode = 1'b0;
            repeat (4) @(negedge pclk);
        end

        // overflow: three lines while stalled
        do_reset();
        ready_mode = 1'b0;
        ready_lvl  = 1'b0;
        cap.delete();
        o0 = ovf_cnt;
        pix(0, 16, 12'd5, 11'd3, 24'h000000);
        check("ovf_none", ovf_cnt - o0, 0);
        pix(0, 16, 12'd6, 11'd4, 24'h000100);
        pix(0, 16, 12'd7, 11'd5, 24'h000200);
        repeat (4) @(negedge pclk);
        check("ovf_pulses", ovf_cnt - o0, 4);
        check("ovf_stall_cnt", cap.size(), 0);
        ready_lvl = 1'b1;
        wait_words(18, "ovf");
        check_pkt(0, 24'h005006, 24'h000000, "ovfA");
        check_pkt(9, 24'h005007, 24'h000008, "ovfB");
        if (cap.size() >= 10)
            check("ovf_b2b", (cap[9].c - cap[8].c) <= 2, 1);
`ifdef HLP_STATS_EN
        check("drop_cnt", drop_cnt, 16'd4);
        check("pkt_cnt", pkt_cnt, 16'd2);
`endif

        // short half, then a full line
        cap.delete();
        o0 = ovf_cnt;
        pix(0, 5, 12'd9, 11'd2, 24'h000500);
        repeat (20) @(negedge pclk);
        check("short_cnt", cap.size(), 0);
        check("short_ovf", ovf_cnt - o0, 0);
        pix(0, 16, 12'd9, 11'd2, 24'h000500);
        wait_words(18, "short");
        check_pkt(0, 24'h009004, 24'h000500, "shA");
        check_pkt(9, 24'h009005, 24'h000508, "shB");

        // reset in the middle of a packet body
        cap.delete();
        nb = 0;
        fork
            pix(0, 16, 12'd3, 11'd1, 24'h007000);
            begin
                for (int k = 0; k < 200 && cap.size() < 3; k++)
                    @(negedge pclk);
                check("rst_reach", cap.size() >= 3, 1);
                #2;
                rstbtn_n = 1'b1;
                nb = cap.size();
                #1;
                check("rst_mid_valid", out_valid, 0);
                check("rst_mid_data", out_data, 0);
                repeat (2) @(negedge pclk);
                rstbtn_n = 1'b0;
            end
        join
        repeat (30) @(negedge pclk);
        check("rst_no_resume", cap.size(), nb);
        cap.delete();
        pix(0, 16, 12'd4, 11'd2, 24'h008000);
        wait_words(18, "post_rst");
        check_pkt(0, 24'h004004, 24'h008000, "prA");
        check_pkt(9, 24'h004005, 24'h008008, "prB");

`ifdef HLP_STATS_EN
        // saturate drop_cnt with a half start every cycle
        ready_lvl = 1'b0;
        cap.delete();
        pix(0, 16, 12'd1, 11'd1, 24'h000000);
        for (int i = 0; i < 70000; i++) begin
            @(posedge pclk);
            #1;
            video_en   = 1'b1;
            video_hcnt = (i % 2 == 0) ? 11'd0 : 11'd8;
        end
        @(posedge pclk);
        #1;
        video_en = 1'b0;
        repeat (4) @(negedge pclk);
        check("drop_sat", drop_cnt, 16'hFFFF);
        ready_lvl = 1'b1;
        repeat (40) @(negedge pclk);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
